// File: rtl/ps2_key_event.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deframes 11-bit frames,
// folds E0/F0 prefixes into flags and queues key events in a fall-through FIFO.
module ps2_key_event #(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 50000
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic                   ps2_clk,
    input  logic                   ps2_data,
    input  logic                   evt_ready,
    input  logic                   clr_flags,
    output logic                   evt_valid,
    output logic [7:0]             evt_code,
    output logic                   evt_ext,
    output logic                   evt_break,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic                   parity_err
);
    // state  | meaning
    // IDLE   | waiting for a start bit (bit counter 0)
    // RECV   | shifting in bits 1..10, timeout armed
    // CHECK  | one cycle: validate frame and decode prefixes
    typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_CHECK} state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    state_t                 st_q, st_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [10:0]            frame_q, frame_d;
    logic [TW-1:0]          tmr_q, tmr_d;
    logic                   ext_q, ext_d, brk_q, brk_d;
    logic                   push_q, push_d;
    logic [9:0]             push_data_q, push_data_d;
    logic [9:0]             mem_q [DEPTH];
    logic [9:0]             mem_d [DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic                   ovf_q, ovf_d, perr_q, perr_d;

    logic       clk_s, data_s, fall, good, perr_set, ovf_set, do_pop, do_write;
    logic [7:0] rx_byte;
    logic [9:0] head;

    assign clk_s   = clk_sync_q[SYNC_STAGES-1];
    assign data_s  = data_sync_q[SYNC_STAGES-1];
    assign fall    = clk_prev_q & ~clk_s;
    assign rx_byte = frame_q[8:1];
    assign good    = ~frame_q[0] & frame_q[10] & (^frame_q[9:1]);

    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d  = clk_s;
        st_d        = st_q;
        bit_cnt_d   = bit_cnt_q;
        frame_d     = frame_q;
        tmr_d       = tmr_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        perr_set    = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (fall && !data_s) begin
                    frame_d[0] = 1'b0;
                    bit_cnt_d  = 4'd1;
                    tmr_d      = TMR_LOAD;
                    st_d       = ST_RECV;
                end
            end
            ST_RECV: begin
                if (fall) begin
                    frame_d[bit_cnt_q] = data_s;
                    tmr_d = TMR_LOAD;
                    if (bit_cnt_q == 4'd10) begin
                        bit_cnt_d = 4'd0;
                        st_d      = ST_CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (tmr_q == '0) begin
                    st_d      = ST_IDLE;
                    bit_cnt_d = 4'd0;
                    ext_d     = 1'b0;
                    brk_d     = 1'b0;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            ST_CHECK: begin
                st_d  = ST_IDLE;
                tmr_d = '0;
                if (!good) begin
                    perr_set = 1'b1;
                    ext_d    = 1'b0;
                    brk_d    = 1'b0;
                end else if (rx_byte == 8'hE0) begin
                    ext_d = 1'b1;
                end else if (rx_byte == 8'hF0) begin
                    brk_d = 1'b1;
                end else begin
                    push_d      = 1'b1;
                    push_data_d = {ext_q, brk_q, rx_byte};
                    ext_d       = 1'b0;
                    brk_d       = 1'b0;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    // When full, a simultaneous pop frees the head slot, which is also the write slot.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_set  = 1'b0;
        do_write = 1'b0;
        do_pop   = (count_q != '0) && evt_ready;
        if (push_q) begin
            if (count_q == (AW+1)'(DEPTH) && !do_pop) begin
                ovf_set = 1'b1;
            end else begin
                mem_d[wr_ptr_q] = push_data_q;
                wr_ptr_d        = wr_ptr_q + AW'(1);
                do_write        = 1'b1;
            end
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q;
        if (do_write && !do_pop)      count_d = count_q + (AW+1)'(1);
        else if (!do_write && do_pop) count_d = count_q - (AW+1)'(1);
        ovf_d  = (ovf_q & ~clr_flags) | ovf_set;
        perr_d = (perr_q & ~clr_flags) | perr_set;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            st_q        <= ST_IDLE;
            bit_cnt_q   <= '0;
            frame_q     <= '0;
            tmr_q       <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            st_q        <= st_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            tmr_q       <= tmr_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            perr_q      <= perr_d;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign evt_valid  = (count_q != '0);
    assign evt_code   = evt_valid ? head[7:0] : 8'h00;
    assign evt_ext    = evt_valid & head[9];
    assign evt_break  = evt_valid & head[8];
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign parity_err = perr_q;
endmodule

// File: tb/tb_ps2_key_event.sv
// Directed bench for ps2_key_event: drives PS/2 frames and checks the event FIFO.
module tb_ps2_key_event;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 200;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       evt_ready = 1'b0;
    logic       clr_flags = 1'b0;
    logic       evt_valid, evt_ext, evt_break, overflow, parity_err;
    logic [7:0] evt_code;
    logic [2:0] fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    ps2_key_event #(.DEPTH(DEPTH), .SYNC_STAGES(2), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .evt_ready(evt_ready), .clr_flags(clr_flags), .evt_valid(evt_valid),
        .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break),
        .fifo_count(fifo_count), .overflow(overflow), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One PS/2 bit: data settles, then a low pulse of ps2_clk several clk cycles long.
    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (4) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (8) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] code, input logic flip_par);
        logic par;
        par = ~(^code) ^ flip_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit(par);
        send_bit(1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", evt_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_code", evt_code, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_perr", parity_err, 0);
        clrn = 1'b1;
        repeat (5) @(posedge clk);

        send_frame(8'h1C, 1'b0);
        chk("make_valid", evt_valid, 1);
        chk("make_code", evt_code, 8'h1C);
        chk("make_ext", evt_ext, 0);
        chk("make_brk", evt_break, 0);
        chk("make_count", fifo_count, 1);
        pop_one();
        chk("make_pop_count", fifo_count, 0);
        chk("make_pop_valid", evt_valid, 0);

        send_frame(8'hF0, 1'b0);
        chk("f0_alone_count", fifo_count, 0);
        send_frame(8'h1C, 1'b0);
        chk("brk_count", fifo_count, 1);
        chk("brk_code", evt_code, 8'h1C);
        chk("brk_brk", evt_break, 1);
        chk("brk_ext", evt_ext, 0);
        pop_one();

        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        chk("extbrk_count", fifo_count, 1);
        chk("extbrk_code", evt_code, 8'h75);
        chk("extbrk_ext", evt_ext, 1);
        chk("extbrk_brk", evt_break, 1);
        pop_one();
        send_frame(8'h75, 1'b0);
        chk("plain_code", evt_code, 8'h75);
        chk("plain_ext", evt_ext, 0);
        chk("plain_brk", evt_break, 0);
        pop_one();
        chk("plain_pop_count", fifo_count, 0);

        send_frame(8'h1C, 1'b1);
        chk("badpar_count", fifo_count, 0);
        chk("badpar_perr", parity_err, 1);
        pulse_clr();
        chk("badpar_clr", parity_err, 0);

        for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 1'b0);
        chk("full_count", fifo_count, DEPTH);
        chk("full_ovf", overflow, 1);
        for (int i = 1; i <= DEPTH; i++) begin
            chk("drain_code", evt_code, i);
            pop_one();
        end
        chk("drain_count", fifo_count, 0);
        chk("drain_valid", evt_valid, 0);
        pulse_clr();
        chk("ovf_clr", overflow, 0);

        for (int i = 0; i < 5; i++) send_bit(1'b0);
        repeat (TIMEOUT + 10) @(posedge clk);
        send_frame(8'h29, 1'b0);
        chk("tmo_count", fifo_count, 1);
        chk("tmo_code", evt_code, 8'h29);
        chk("tmo_perr", parity_err, 0);
        pop_one();

        for (int i = 0; i < 4; i++) send_bit(1'b0);
        @(negedge clk);
        clrn = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_count", fifo_count, 0);
        clrn = 1'b1;
        repeat (5) @(posedge clk);
        send_frame(8'h29, 1'b0);
        chk("midrst_evt_count", fifo_count, 1);
        chk("midrst_code", evt_code, 8'h29);
        chk("midrst_perr", parity_err, 0);
        pop_one();
        chk("midrst_pop_count", fifo_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_key_event.md
PS2_KEY_EVENT -- requirements
Module: ps2_key_event

Interface
REQ-001 Parameter DEPTH, default 8, event FIFO entries; power of two, at least 2.
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser flops on ps2_clk and ps2_data; at least 2.
REQ-003 Parameter TIMEOUT, default 50000, clk cycles without a ps2_clk falling edge before a partial frame is aborted.
REQ-004 clk  input  1  system clock; single clock domain; all state on rising edge.
REQ-005 clrn  input  1  reset, asynchronous, active-low.
REQ-006 ps2_clk  input  1  PS/2 device clock, asynchronous to clk.
REQ-007 ps2_data  input  1  PS/2 device data, asynchronous to clk.
REQ-008 evt_ready  input  1  consumer accepts head event this cycle.
REQ-009 clr_flags  input  1  one-cycle pulse; clears overflow and parity_err.
REQ-010 evt_valid  output  1  FIFO not empty; head event presented.
REQ-011 evt_code  output  8  head event scan code.
REQ-012 evt_ext  output  1  head event was preceded by E0.
REQ-013 evt_break  output  1  head event was preceded by F0 (key release).
REQ-014 fifo_count  output  $clog2(DEPTH)+1  number of events stored.
REQ-015 overflow  output  1  sticky; an event was dropped because the FIFO was full.
REQ-016 parity_err  output  1  sticky; a frame was rejected (parity, start or stop error).

Function
REQ-017 ps2_clk and ps2_data SHALL pass through SYNC_STAGES flops; a falling edge is synchronised ps2_clk going 1 to 0 between consecutive clk cycles.
REQ-018 The receiver SHALL sample ps2_data on each falling edge: 11-bit frame = start(0), d[0]..d[7] LSB first, odd parity, stop(1); a bit counter runs 0..10.
REQ-019 Receiver states SHALL be IDLE (counter 0), RECV (counter 1..10), and a 1-cycle CHECK after bit 10 is sampled; CHECK returns to IDLE.
REQ-020 In IDLE, a falling edge with sampled data 1 SHALL be ignored, and the receiver stays in IDLE.
REQ-021 In CHECK, a frame is good iff start=0, stop=1 and XOR(d[7:0],parity)=1; a bad frame sets parity_err and the byte is discarded.
REQ-022 In RECV, TIMEOUT consecutive clk cycles without a falling edge SHALL abort to IDLE with no byte and no flag change.
REQ-023 Prefix decoder, good byte E0: set the ext flag and push nothing.
REQ-024 Prefix decoder, good byte F0: set the brk flag and push nothing.
REQ-025 Prefix decoder, any other good byte: push {ext, brk, byte}, then clear both flags in the same cycle.
REQ-026 A bad frame or a timeout SHALL also clear the ext and brk flags.
REQ-027 The FIFO SHALL be first-word fall-through; evt_code, evt_ext and evt_break reflect the head entry whenever evt_valid=1.
REQ-028 A pop SHALL occur on a clk edge where evt_valid=1 and evt_ready=1; evt_ready while empty has no effect.
REQ-029 A push SHALL occur in the cycle after CHECK; evt_valid rises on the following edge when the FIFO was empty (a good frame reaches evt_valid 2 clk after the stop-bit edge is detected).
REQ-030 Push while full without a simultaneous pop: drop the event, set overflow, and leave FIFO contents unchanged.
REQ-031 Push and pop in the same cycle SHALL both complete, including when full; fifo_count is unchanged and overflow is not set.
REQ-032 Read and write pointers SHALL wrap modulo DEPTH; fifo_count stays in 0..DEPTH.
REQ-033 clr_flags SHALL clear the sticky flags; if a set condition occurs in the same cycle, set wins.

Reset
REQ-034 clrn=0 SHALL immediately force: receiver IDLE, counter 0, timeout counter 0, ext=brk=0, FIFO empty, fifo_count=0, evt_valid=0, evt_code=0, evt_ext=0, evt_break=0, overflow=0, parity_err=0.
REQ-035 Synchroniser flops SHALL reset to 1 (bus idle), so that releasing reset does not create a falling edge.
REQ-036 Reset asserted mid-frame SHALL discard the partial frame; after release, the receiver accepts only a fresh start bit.

Verification
REQ-037 Frame 0x1C, good parity -> evt_valid=1, evt_code=1C, evt_ext=0, evt_break=0, fifo_count=1; evt_ready pulse -> fifo_count=0.
REQ-038 Frames F0, 1C -> exactly one event: code 1C, break=1, ext=0.
REQ-039 Frames E0, F0, 75 -> one event: code 75, ext=1, break=1; then frame 75 -> code 75, ext=0, break=0.
REQ-040 Frame 0x1C with parity flipped -> no event, parity_err=1; clr_flags -> parity_err=0.
REQ-041 DEPTH+1 make codes 01..DEPTH+1 with evt_ready=0 -> fifo_count=DEPTH, overflow=1; drain -> codes 01..DEPTH in order.
REQ-042 Case A: 5 bits, then idle TIMEOUT+10 cycles, then frame 0x29 -> one event 29, parity_err=0. Case B: clrn pulsed mid-frame, then frame 0x29 -> one event 29.
